div_issue: RTL and testbench
============================

# div_issue

Issue/retire controller for the integer divider in the execute stage. Accepts RISC-V DIV/DIVU/REM/REMU operations from the execute stage over valid/ready, and resolves divide-by-zero and unsigned divisor-MSB cases locally. It runs the signed `div` core for everything else, corrects unsigned results whose dividend MSB is set, and returns one tagged 32-bit result to writeback over valid/ready.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported, because the divider core is fixed at 32.
- `TAG_W`, 5: width of the destination tag carried alongside the op.
- `clk_i`  in  1: clock. One clock domain.
- `rst_ni`  in  1: reset, synchronous and active-low.
- `in_valid_i`  in  1: op offered.
- `in_ready_o`  out  1: op accepted when high together with `in_valid_i`.
- `in_op_i`  in  2: operation select.
  - 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `in_a_i`  in  XLEN: dividend.
- `in_b_i`  in  XLEN: divisor.
- `in_tag_i`  in  TAG_W: destination tag.
- `flush_i`  in  1: kill the op in flight and any pending result.
- `out_valid_o`  out  1: result valid.
- `out_ready_i`  in  1: writeback accepts the result.
- `out_data_o`  out  XLEN: result (quotient or remainder).
- `out_tag_o`  out  TAG_W: tag of the result.
- `busy_o`  out  1: state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, OUT, DRAIN.
- `in_ready_o` = (state == IDLE) & ~`flush_i`.
- On accept, the block registers op, tag, `a`, `b` and the `is_rem` flag, then classifies the op:
  - b == 0: local result. Quotient = all ones, remainder = a. Next state OUT.
  - Unsigned op with b[31] = 1: local result. q = (a >= b); r = q ? a - b : a. Next state OUT.
  - Unsigned op with a[31] = 1 (b[31] = 0): split mode. Issue a' = {1'b0, a[31:1]} and b. Next state ISSUE.
  - All other ops: issue a and b unchanged. Next state ISSUE.
  - Signed overflow and sign fixup are left to the core. 0x80000000 / 0xFFFFFFFF yields q = 0x80000000, r = 0.
- ISSUE: drive the core's `req_i` high for exactly one cycle, with operands held stable in registers. Next state WAIT.
- WAIT: hold until the core's `ready_o` pulse. In that cycle, take `q_o`/`r_o` and register the final result. Next state OUT.
  - Split-mode correction: r2 = {r1[30:0], a[0]}.
    - If r2 >= b: q = {q1[30:0], 1'b1}, r = r2 - b.
    - Otherwise: q = {q1[30:0], 1'b0}, r = r2.
  - r1 < b < 2^31, so r2 fits in 32 bits.
- OUT: `out_valid_o` = 1, with `out_data_o` = `is_rem` ? r : q. Data and tag stay stable until `out_valid_o & out_ready_i`, then next state IDLE. No new op is accepted in OUT.
- The core's `ready_o` is ignored in IDLE, ISSUE and OUT.
- Flush behaviour (flush has priority over every other event in the same cycle):
  - In IDLE or OUT: go to IDLE and drop the result. A same-cycle `in_valid_i` is not accepted.
  - In ISSUE or WAIT: go to DRAIN. The core cannot be aborted.
  - If the core's `ready_o` pulse arrives in the same WAIT cycle as `flush_i`, the state goes to IDLE and the result is discarded.
  - DRAIN: wait for the core's `ready_o` pulse, discard the result, go to IDLE. Flush has no further effect here.
- Reset (`rst_ni` low at a clock edge) forces:
  - state to IDLE;
  - `out_valid_o`, `out_data_o`, `out_tag_o` and `busy_o` to 0, and `in_ready_o` to 0 while `rst_ni` is low;
  - the core's `rst_i` = ~`rst_ni`, so the core resets on the same edge.
- A reset mid-operation abandons the op with no output.

## Timing
- Local result: op accepted at edge T; `out_valid_o` is high from cycle T+1.
- Core path: accepted at T; `req_i` is high in cycle T+1. With the core's `ready_o` pulse in cycle T+1+L, `out_valid_o` is high from T+2+L.
  - L is the core latency and is not assumed fixed. It is shorter when a' == 0.
- Throughput: one op in flight. The earliest next accept is the cycle after the output handshake.
- All outputs are registered except `in_ready_o` and `busy_o`, which decode from state.

## Structure
- Shared package `div_pkg`:
  - op encodings: `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`;
  - state enum;
  - `XLEN` constant.
- One sub-module: `div`, instantiated with `rst_i` tied to ~`rst_ni`.
- Correction and local-result logic stay inline.

## Test plan
- Signed ops:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; the REM form -> 0.
- Split mode:
  - DIVU 0xFFFFFFFF / 3 -> 0x55555555.
  - REMU 0xFFFFFFFE / 7 -> 2.
  - DIVU 0x80000000 / 1 -> 0x80000000.
- Local paths, each with `out_valid_o` at T+1 and `req_i` never asserted:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REM 0x80000000 / 0 -> 0x80000000.
  - REMU 9 / 0x80000001 -> 9.
  - DIVU 0xF0000000 / 0x80000000 -> 1.
- Backpressure: hold `out_ready_i` low for 10 cycles.
  - Required: `out_valid_o`, data and tag stay stable, and `in_ready_o` stays 0.
  - Release `out_ready_i`: the next op is accepted the following cycle with the correct tag.
- Flush in WAIT:
  - Required: no `out_valid_o`, `busy_o` high and `in_ready_o` low until the core's `ready_o` pulse, then IDLE.
  - A following DIV 100 / 7 -> 14.
- Reset with `rst_ni` low for 2 cycles mid-WAIT:
  - Required: all outputs 0 and no stray result.
  - A following REM 100 / 7 -> 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the execute-stage divider.
// Op encodings, FSM states and datapath width.
package div_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/div_issue_if.sv
// Execute-stage <-> divider <-> writeback handshake bundle.
// Slave is the divider controller, master is its environment.
interface div_issue_if #(
  parameter int TAG_W = 5
);
  import div_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       in_op_i;
  logic [XLEN-1:0]  in_a_i;
  logic [XLEN-1:0]  in_b_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  out_data_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             busy_o;

  modport slave (
    input  in_valid_i, in_op_i, in_a_i,
    input  in_b_i, in_tag_i, flush_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o,
    output out_data_o, out_tag_o, busy_o
  );

  modport master (
    output in_valid_i, in_op_i, in_a_i,
    output in_b_i, in_tag_i, flush_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o,
    input  out_data_o, out_tag_o, busy_o
  );
endinterface

// File: rtl/div.sv
// Iterative signed 32-bit divider core, one quotient bit per cycle.
// A zero dividend finishes on the cycle after req_i.
module div
  import div_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic [XLEN-1:0] q_o,
  output logic [XLEN-1:0] r_o
);
  logic            r_busy;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_negq;
  logic            r_negr;
  logic            r_rdy;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_r;

  logic [XLEN-1:0] w_amag;
  logic [XLEN-1:0] w_bmag;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_nrem;
  logic [XLEN-1:0] w_nquo;

  assign w_amag = a_i[XLEN-1] ? -a_i : a_i;
  assign w_bmag = b_i[XLEN-1] ? -b_i : b_i;
  assign w_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_dvs};
  assign w_ge   = ~w_diff[XLEN];
  assign w_nrem = w_ge ? w_diff[XLEN-1:0]
                       : w_sh[XLEN-1:0];
  assign w_nquo = {r_quo[XLEN-2:0], w_ge};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_rdy  <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
    end else begin
      r_rdy <= 1'b0;
      if (!r_busy) begin
        if (req_i) begin
          r_negq <= a_i[XLEN-1] ^ b_i[XLEN-1];
          r_negr <= a_i[XLEN-1];
          if (w_amag == '0) begin
            r_q   <= '0;
            r_r   <= '0;
            r_rdy <= 1'b1;
          end else begin
            r_busy <= 1'b1;
            r_cnt  <= 5'd31;
            r_rem  <= '0;
            r_quo  <= w_amag;
            r_dvs  <= w_bmag;
          end
        end
      end else begin
        r_rem <= w_nrem;
        r_quo <= w_nquo;
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_rdy  <= 1'b1;
          r_q    <= r_negq ? -w_nquo : w_nquo;
          r_r    <= r_negr ? -w_nrem : w_nrem;
        end
      end
    end
  end

  assign ready_o = r_rdy;
  assign q_o     = r_q;
  assign r_o     = r_r;
endmodule

// File: rtl/div_issue.sv
// Issue/retire controller for the divider core.
// Resolves x/0 and large unsigned divisors locally.
module div_issue
  import div_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input logic        clk_i,
  input logic        rst_ni,
  div_issue_if.slave bus
);
  state_e           r_state;
  logic             r_valid;
  logic [XLEN-1:0]  r_data;
  logic [TAG_W-1:0] r_tag;
  logic             r_req;
  logic [XLEN-1:0]  r_ca;
  logic [XLEN-1:0]  r_b;
  logic             r_a0;
  logic             r_is_rem;
  logic             r_split;

  logic            w_rst;
  logic            w_crdy;
  logic [XLEN-1:0] w_cq;
  logic [XLEN-1:0] w_cr;
  logic            w_acc;
  logic            w_uns;
  logic            w_rem;
  logic            w_bz;
  logic            w_ubig;
  logic            w_lq;
  logic [XLEN-1:0] w_lr;
  logic [XLEN-1:0] w_r2;
  logic            w_ge;
  logic [XLEN-1:0] w_fq;
  logic [XLEN-1:0] w_fr;
  logic [XLEN-1:0] w_res;

  assign w_rst = ~rst_ni;
  assign w_acc = bus.in_valid_i
              && bus.in_ready_o;
  assign w_uns = (bus.in_op_i == DIV_OP_DIVU)
              || (bus.in_op_i == DIV_OP_REMU);
  assign w_rem = (bus.in_op_i == DIV_OP_REM)
              || (bus.in_op_i == DIV_OP_REMU);
  assign w_bz   = bus.in_b_i == '0;
  assign w_ubig = w_uns && bus.in_b_i[XLEN-1];
  assign w_lq   = bus.in_a_i >= bus.in_b_i;
  assign w_lr   = w_lq ? bus.in_a_i - bus.in_b_i
                       : bus.in_a_i;

  // Split mode restores the dividend LSB dropped before issue
  assign w_r2  = {w_cr[XLEN-2:0], r_a0};
  assign w_ge  = w_r2 >= r_b;
  assign w_fq  = r_split ? {w_cq[XLEN-2:0], w_ge}
                         : w_cq;
  assign w_fr  = r_split ? (w_ge ? w_r2 - r_b : w_r2)
                         : w_cr;
  assign w_res = r_is_rem ? w_fr : w_fq;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_tag    <= '0;
      r_req    <= 1'b0;
      r_ca     <= '0;
      r_b      <= '0;
      r_a0     <= 1'b0;
      r_is_rem <= 1'b0;
      r_split  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_acc) begin
          r_tag    <= bus.in_tag_i;
          r_b      <= bus.in_b_i;
          r_a0     <= bus.in_a_i[0];
          r_is_rem <= w_rem;
          r_split  <= 1'b0;
          unique case (1'b1)
            w_bz: begin
              r_data  <= w_rem ? bus.in_a_i : '1;
              r_valid <= 1'b1;
              r_state <= S_OUT;
            end
            w_ubig: begin
              r_data  <= w_rem ? w_lr
                       : {{(XLEN-1){1'b0}}, w_lq};
              r_valid <= 1'b1;
              r_state <= S_OUT;
            end
            default: begin
              if (w_uns && bus.in_a_i[XLEN-1]) begin
                r_ca    <= {1'b0, bus.in_a_i[XLEN-1:1]};
                r_split <= 1'b1;
              end else begin
                r_ca    <= bus.in_a_i;
              end
              r_req   <= 1'b1;
              r_state <= S_ISSUE;
            end
          endcase
        end
        S_ISSUE: begin
          r_req   <= 1'b0;
          r_state <= bus.flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (bus.flush_i) begin
            r_state <= w_crdy ? S_IDLE : S_DRAIN;
          end else if (w_crdy) begin
            r_data  <= w_res;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.flush_i || bus.out_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: if (w_crdy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  div u_div (
    .clk_i   (clk_i),
    .rst_i   (w_rst),
    .req_i   (r_req),
    .a_i     (r_ca),
    .b_i     (r_b),
    .ready_o (w_crdy),
    .q_o     (w_cq),
    .r_o     (w_cr)
  );

  assign bus.in_ready_o  = rst_ni
                        && (r_state == S_IDLE)
                        && !bus.flush_i;
  assign bus.busy_o      = r_state != S_IDLE;
  assign bus.out_valid_o = r_valid;
  assign bus.out_data_o  = r_data;
  assign bus.out_tag_o   = r_tag;
endmodule

// File: tb/tb_div_issue.sv
// Directed self-checking bench for div_issue.
// Inputs change 1ns after posedge, outputs sampled there.
module tb_div_issue;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   req_cnt = 0;

  div_issue_if #(.TAG_W(5)) bus ();

  div_issue #(.TAG_W(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (dut.r_req) req_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL timeout global");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", t, obs, exp);
    end
  endtask

  task automatic run_op(input string nm,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] tag,
                        input logic [31:0] exp,
                        input bit loc);
    int n;
    int rq;
    bus.in_op_i    = op;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
    bus.in_tag_i   = tag;
    bus.in_valid_i = 1'b1;
    n = 0;
    while (!bus.in_ready_o && n < 20) begin
      step();
      n++;
    end
    chk({nm, ".acc"}, 32'(n < 20), 32'd1);
    rq = req_cnt;
    step();
    bus.in_valid_i = 1'b0;
    if (loc) begin
      chk({nm, ".t1"}, 32'(bus.out_valid_o), 32'd1);
    end else begin
      n = 0;
      while (!bus.out_valid_o && n < 200) begin
        step();
        n++;
      end
      chk({nm, ".to"}, 32'(n < 200), 32'd1);
    end
    chk({nm, ".d"}, bus.out_data_o, exp);
    chk({nm, ".tag"}, 32'(bus.out_tag_o), 32'(tag));
    chk({nm, ".req"}, 32'(req_cnt - rq),
        loc ? 32'd0 : 32'd1);
    step();
    chk({nm, ".done"}, 32'(bus.out_valid_o), 32'd0);
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  seen;
    logic [31:0] hd;
    bus.in_valid_i  = 1'b0;
    bus.in_op_i     = 2'b00;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.in_tag_i    = '0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    step();
    chk("rst.ov", 32'(bus.out_valid_o), 32'd0);
    chk("rst.d", bus.out_data_o, 32'd0);
    chk("rst.tag", 32'(bus.out_tag_o), 32'd0);
    chk("rst.busy", 32'(bus.busy_o), 32'd0);
    chk("rst.rdy", 32'(bus.in_ready_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.rdy1", 32'(bus.in_ready_o), 32'd1);
    step();

    run_op("div_n", DIV_OP_DIV, 32'hFFFFFFF9,
           32'd2, 5'd1, 32'hFFFFFFFD, 1'b0);
    run_op("rem_n", DIV_OP_REM, 32'hFFFFFFF9,
           32'd2, 5'd2, 32'hFFFFFFFF, 1'b0);
    run_op("div_ov", DIV_OP_DIV, 32'h80000000,
           32'hFFFFFFFF, 5'd3, 32'h80000000, 1'b0);
    run_op("rem_ov", DIV_OP_REM, 32'h80000000,
           32'hFFFFFFFF, 5'd4, 32'h0, 1'b0);
    run_op("divu_sp", DIV_OP_DIVU, 32'hFFFFFFFF,
           32'd3, 5'd5, 32'h55555555, 1'b0);
    run_op("remu_sp", DIV_OP_REMU, 32'hFFFFFFFE,
           32'd7, 5'd6, 32'd2, 1'b0);
    run_op("divu_sp1", DIV_OP_DIVU, 32'h80000000,
           32'd1, 5'd7, 32'h80000000, 1'b0);
    run_op("divu_z", DIV_OP_DIVU, 32'd5,
           32'd0, 5'd8, 32'hFFFFFFFF, 1'b1);
    run_op("rem_z", DIV_OP_REM, 32'h80000000,
           32'd0, 5'd9, 32'h80000000, 1'b1);
    run_op("remu_big", DIV_OP_REMU, 32'd9,
           32'h80000001, 5'd10, 32'd9, 1'b1);
    run_op("divu_big", DIV_OP_DIVU, 32'hF0000000,
           32'h80000000, 5'd11, 32'd1, 1'b1);

    // Backpressure, with the next op offered meanwhile
    bus.out_ready_i = 1'b0;
    bus.in_op_i     = DIV_OP_DIVU;
    bus.in_a_i      = 32'd100;
    bus.in_b_i      = 32'd7;
    bus.in_tag_i    = 5'd12;
    bus.in_valid_i  = 1'b1;
    step();
    bus.in_op_i     = DIV_OP_DIVU;
    bus.in_a_i      = 32'd5;
    bus.in_b_i      = 32'd0;
    bus.in_tag_i    = 5'd13;
    n = 0;
    while (!bus.out_valid_o && n < 200) begin
      step();
      n++;
    end
    chk("bp.to", 32'(n < 200), 32'd1);
    hd = bus.out_data_o;
    chk("bp.d", hd, 32'd14);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ok &= bus.out_valid_o === 1'b1;
      ok &= bus.out_data_o === 32'd14;
      ok &= bus.out_tag_o === 5'd12;
      ok &= bus.in_ready_o === 1'b0;
      step();
    end
    chk("bp.hold", 32'(ok), 32'd1);
    bus.out_ready_i = 1'b1;
    step();
    chk("bp.hs", 32'(bus.out_valid_o), 32'd0);
    chk("bp.rdy", 32'(bus.in_ready_o), 32'd1);
    step();
    bus.in_valid_i = 1'b0;
    chk("bp2.ov", 32'(bus.out_valid_o), 32'd1);
    chk("bp2.d", bus.out_data_o, 32'hFFFFFFFF);
    chk("bp2.tag", 32'(bus.out_tag_o), 32'd13);
    step();

    // Flush while waiting on the core
    bus.in_op_i    = DIV_OP_DIV;
    bus.in_a_i     = 32'd100;
    bus.in_b_i     = 32'd7;
    bus.in_tag_i   = 5'd14;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    ok = 1'b1;
    n = 0;
    while (!dut.w_crdy && n < 100) begin
      ok &= bus.out_valid_o === 1'b0;
      ok &= bus.busy_o === 1'b1;
      ok &= bus.in_ready_o === 1'b0;
      step();
      n++;
    end
    chk("fl.to", 32'(n < 100), 32'd1);
    chk("fl.hold", 32'(ok), 32'd1);
    chk("fl.ovp", 32'(bus.out_valid_o), 32'd0);
    step();
    chk("fl.busy", 32'(bus.busy_o), 32'd0);
    chk("fl.rdy", 32'(bus.in_ready_o), 32'd1);
    chk("fl.ov", 32'(bus.out_valid_o), 32'd0);
    run_op("fl_div", DIV_OP_DIV, 32'd100,
           32'd7, 5'd15, 32'd14, 1'b0);

    // Reset mid-WAIT
    bus.in_op_i    = DIV_OP_DIV;
    bus.in_a_i     = 32'hFFFFFFF9;
    bus.in_b_i     = 32'd2;
    bus.in_tag_i   = 5'd16;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    step();
    chk("mr.ov", 32'(bus.out_valid_o), 32'd0);
    chk("mr.d", bus.out_data_o, 32'd0);
    chk("mr.tag", 32'(bus.out_tag_o), 32'd0);
    chk("mr.busy", 32'(bus.busy_o), 32'd0);
    chk("mr.rdy", 32'(bus.in_ready_o), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      seen |= bus.out_valid_o === 1'b1;
      step();
    end
    chk("mr.stray", 32'(seen), 32'd0);
    run_op("mr_rem", DIV_OP_REM, 32'd100,
           32'd7, 5'd17, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
